// File: rtl/dm_pkg.sv
// Shared access-type encodings and the legality/alignment rule for dm_unit.
package dm_pkg;

  localparam logic [2:0] dm_word              = 3'b000;
  localparam logic [2:0] dm_halfword          = 3'b001;
  localparam logic [2:0] dm_halfword_unsigned = 3'b010;
  localparam logic [2:0] dm_byte              = 3'b011;
  localparam logic [2:0] dm_byte_unsigned     = 3'b100;

  // True when the type is legal and the address is naturally aligned for it.
  function automatic logic dm_legal(input logic [2:0] dm_type, input logic [1:0] addr_lo);
    logic ok;
    case (dm_type)
      dm_word:                           ok = (addr_lo == 2'b00);
      dm_halfword, dm_halfword_unsigned: ok = !addr_lo[0];
      dm_byte, dm_byte_unsigned:         ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_align.sv
// Combinational lane steering: store byte enables/replication and load extract/extend.
module dm_align
  import dm_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] word_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_data,
  output logic [31:0] load_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign half_sel = addr_lo[1] ? word_data[31:16] : word_data[15:0];
  assign byte_sel = addr_lo[0] ? half_sel[15:8] : half_sel[7:0];

  always_comb begin
    byte_en   = 4'b0000;
    wr_data   = store_data;
    load_data = word_data;
    case (dm_type)
      dm_word: begin
        byte_en = 4'b1111;
      end
      dm_halfword, dm_halfword_unsigned: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{store_data[15:0]}};
        load_data = (dm_type == dm_halfword) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
      end
      dm_byte, dm_byte_unsigned: begin
        byte_en   = 4'b0001 << addr_lo;
        wr_data   = {4{store_data[7:0]}};
        load_data = (dm_type == dm_byte) ? {{24{byte_sel[7]}}, byte_sel}
                                         : {24'h000000, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// Data memory behind the MEM stage: byte/half/word loads and stores with
// alignment checking, registered load data, error and access-count status.
module dm_unit
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           mem_w,
  input  logic                           mem_r,
  input  logic [31:0]                    Addr_in,
  input  logic [31:0]                    Data_in,
  input  logic [2:0]                     DMType,
  output logic [31:0]                    Data_out,
  output logic                           rvalid,
  output logic                           misalign,
  output logic                           err_sticky,
  output logic [CNT_W-1:0]               acc_cnt,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic          legal;
  logic          rdy;
  logic          req, do_store, do_load, reject, conflict;
  logic [3:0]    byte_en;
  logic [31:0]   wr_data, load_data;
  logic          unused_addr;

  assign widx        = Addr_in[AW+1:2];
  assign unused_addr = ^Addr_in[31:AW+2];
  assign legal       = dm_legal(DMType, Addr_in[1:0]);

  // rdy is low on the reset-release edge, so nothing is accepted on that edge.
  assign req      = (mem_w | mem_r) & rdy;
  assign do_store = mem_w & legal & rdy;
  assign do_load  = mem_r & ~mem_w & legal & rdy;
  assign reject   = req & ~legal;
  assign conflict = mem_w & mem_r & rdy;

  dm_align u_align (
    .dm_type    (DMType),
    .addr_lo    (Addr_in[1:0]),
    .store_data (Data_in),
    .word_data  (mem[widx]),
    .byte_en    (byte_en),
    .wr_data    (wr_data),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy        <= 1'b0;
      Data_out   <= 32'h0;
      rvalid     <= 1'b0;
      misalign   <= 1'b0;
      err_sticky <= 1'b0;
      acc_cnt    <= '0;
    end else begin
      rdy      <= 1'b1;
      rvalid   <= do_load;
      misalign <= reject;
      if (do_load) Data_out <= load_data;
      if (reject || conflict) err_sticky <= 1'b1;
      if (do_store || do_load) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: doc/dm_unit.md
# dm_unit

Data memory for the pipelined CPU, sitting directly downstream of the core's MEM stage. It consumes the core's `Addr_out`, `Data_out`, `mem_w` and `DMType_out`, and returns load data that the MEM/WB register captures as `MemData`. The block handles byte, halfword and word accesses with sign or zero extension, and enforces alignment. It also provides a combinational debug read port for the testbench, plus error and access-count status.

## Interface
Parameters:
- `DEPTH_WORDS`, default 128: number of 32-bit words; must be a power of two.
- `CNT_W`, default 16: width of the access counter.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `mem_w` in 1: store request this cycle.
- `mem_r` in 1: load request this cycle.
- `Addr_in` in 32: byte address.
- `Data_in` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `DMType` in 3: access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 illegal.
- `Data_out` out 32: registered, extended load data.
- `rvalid` out 1: pulses for one cycle when `Data_out` holds a new load result.
- `misalign` out 1: pulses for one cycle after a rejected access.
- `err_sticky` out 1: set by any rejected or conflicting access; held until reset.
- `acc_cnt` out CNT_W: count of completed accesses; wraps.
- `dbg_addr` in log2(DEPTH_WORDS): word index for the debug read.
- `dbg_data` out 32: combinational read of `mem[dbg_addr]`.

## Operation
- Word index is `Addr_in[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so addresses alias and wrap modulo `4*DEPTH_WORDS`.
- Alignment rules:
  - Word access requires `Addr[1:0]==0`.
  - Halfword access requires `Addr[0]==0`.
  - Byte access is always aligned.
- Store, aligned: byte enables are generated from `DMType` and `Addr[1:0]`.
  - `sb` writes lane `Addr[1:0]`.
  - `sh` writes lanes {1,0} or {3,2}.
  - `sw` writes all four lanes.
  - Data is replicated into the selected lanes; unselected bytes are unchanged.
- Load, aligned: the selected byte or halfword is right-shifted to bit 0, then sign-extended (types 001 and 011) or zero-extended (types 010 and 100). Word loads pass through unchanged.
- Rejected access (misaligned or illegal `DMType`):
  - No memory write.
  - `Data_out` holds its previous value and `rvalid` stays 0.
  - `misalign` pulses, `err_sticky` is set, and `acc_cnt` is unchanged.
- `mem_w` and `mem_r` both high:
  - The store executes if it is aligned.
  - No load response is produced.
  - `err_sticky` is set.
  - `acc_cnt` increments by 1.
- `acc_cnt` increments by 1 on each completed store or load response.
- Reset values:
  - `Data_out` = 0, `rvalid` = 0, `misalign` = 0, `err_sticky` = 0, `acc_cnt` = 0.
  - Memory contents are not reset; the bench preloads them or the core writes them.

## Timing
- Store: the write commits at the rising edge where `mem_w=1`. `dbg_data` shows the new value immediately after that edge.
- Load: sampled at edge N. `Data_out` and `rvalid` are valid from edge N until edge N+1, giving 1-cycle latency that matches MEM→WB capture.
- Load to the address stored at the previous edge returns the new data; there is no bypass hazard.
- Back-to-back loads: one result per cycle. `rvalid` stays high continuously, and `Data_out` updates every cycle.
- `misalign` asserts the cycle after the offending request edge, for exactly one cycle per offending request.
- Reset asserted mid-operation:
  - All registered outputs clear immediately (asynchronously).
  - A store on the same edge as reset release is not performed.
  - Memory keeps its contents.
- `dbg_data` is purely combinational and independent of `rstn`.

## Structure
- Package `dm_pkg` holds:
  - `DMType` constants `dm_word`, `dm_halfword`, `dm_halfword_unsigned`, `dm_byte`, `dm_byte_unsigned`.
  - A function `dm_legal(type, addr_lo)` returning alignment and legality.
- Sub-module `dm_align` is purely combinational: it generates byte enables and lane-replicated write data, and extracts and extends load data.
- `dm_unit` holds the array, output registers, counter and sticky flag.

## Test plan
- Reset with `rstn=0` for 20 ns → all outputs 0. Then `sw` 0x12345678 to address 0x10 → `dbg_addr=4` gives `dbg_data` 0x12345678 and `acc_cnt`=1.
- After that store, `sb` 0xAB to 0x11, then `lb` from 0x11 → `Data_out` 0xFFFFFFAB. Then `lbu` from 0x11 → 0x000000AB. Word 4 reads 0x1234AB78.
- `sh` 0x8001 to 0x12, then `lh` from 0x12 → 0xFFFF8001; `lhu` from 0x12 → 0x00008001. `rvalid` stays high across the back-to-back loads.
- `lw` from 0x13 → `misalign` pulses one cycle, `rvalid` stays 0, `Data_out` unchanged, `err_sticky`=1, `acc_cnt` unchanged. Same response for `DMType`=101 at 0x10.
- `mem_w` and `mem_r` both high, `sw` 0xCAFEF00D to 0x20 → word 8 = 0xCAFEF00D, no `rvalid`, `err_sticky`=1. Pulse `rstn` low mid-sequence → outputs clear and word 8 keeps 0xCAFEF00D.
- Address 0x210 with `DEPTH_WORDS`=128 → aliases to word 4. Run 65536 accesses → `acc_cnt` wraps to 0.
